// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives the requests and the release strobe. The slave side
// (the arbiter) returns the registered grant, its encoded owner and the
// timeout pulse.
interface rr_arbiter4_if;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [2:0] gnt_code;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_code,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_code,
      output timeout
   );
endinterface : rr_arbiter4_if

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time.
// A grant lasts until the owner signals done, drops its request, or has held
// the resource for MAX_HOLD cycles. Every grant is followed by one idle cycle.
// The search pointer advances past the owner only when the grant is released.
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          rst,
   rr_arbiter4_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // The hold count on the last cycle a single owner may keep the grant.
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t     state, state_nx;
   logic [3:0] gnt_q, gnt_nx;
   logic [2:0] code_q, code_nx;
   logic       timeout_q, timeout_nx;
   logic [1:0] ptr_q, ptr_nx;
   logic [3:0] hold_q, hold_nx;

   logic [1:0] win_idx;
   logic [1:0] owner;
   logic       rel_done, rel_drop, rel_limit, release_now;

   assign owner = code_q[1:0];

   // Winner search: first set request at or after ptr, wrapping modulo 4.
   always_comb begin
      win_idx = ptr_q;
      // Scan from the farthest offset down, so the nearest requester wins.
      for (int i = 3; i >= 0; i--) begin
         if (bus.req[ptr_q + 2'(i)]) begin
            win_idx = ptr_q + 2'(i);
         end
      end
   end

   // Release conditions for the current owner. These only act while BUSY.
   always_comb begin
      rel_done    = bus.done;
      rel_drop    = !bus.req[owner];
      rel_limit   = (hold_q == HOLD_LAST);
      release_now = rel_done || rel_drop || rel_limit;
   end

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave one
      // unassigned. An unassigned path would infer a latch.
      state_nx   = state;
      gnt_nx     = gnt_q;
      code_nx    = code_q;
      timeout_nx = 1'b0;
      ptr_nx     = ptr_q;
      hold_nx    = hold_q;

      unique case (state)
         IDLE: begin
            if (bus.req != 4'b0000) begin
               state_nx = BUSY;
               gnt_nx   = 4'b0001 << win_idx;
               code_nx  = {1'b1, win_idx};
               hold_nx  = 4'd0;
            end
         end
         BUSY: begin
            if (release_now) begin
               state_nx   = IDLE;
               gnt_nx     = 4'b0000;
               code_nx    = 3'b000;
               ptr_nx     = owner + 2'd1;
               hold_nx    = 4'd0;
               // The timeout pulse marks only a release forced by the hold limit.
               timeout_nx = rel_limit && !rel_done && !rel_drop;
            end else begin
               hold_nx = hold_q + 4'd1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and output registers, with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here, so every register samples the
      // values from before the edge, independent of statement order.
      if (rst) begin
         state     <= IDLE;
         gnt_q     <= 4'b0000;
         code_q    <= 3'b000;
         timeout_q <= 1'b0;
         ptr_q     <= 2'd0;
         hold_q    <= 4'd0;
      end else begin
         state     <= state_nx;
         gnt_q     <= gnt_nx;
         code_q    <= code_nx;
         timeout_q <= timeout_nx;
         ptr_q     <= ptr_nx;
         hold_q    <= hold_nx;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.gnt_code = code_q;
   assign bus.timeout  = timeout_q;

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
// Directed testbench for rr_arbiter4 with MAX_HOLD=8.
// Each task drives one scenario and compares {gnt, gnt_code, timeout} against
// values worked out by hand. The tasks run in order, so the arbiter pointer
// carries over from one scenario to the next.
module tb_rr_arbiter4;

   logic clk = 1'b0;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;

   rr_arbiter4_if bus ();

   rr_arbiter4 #(.MAX_HOLD(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // One clock edge. Outputs are sampled and inputs changed 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [3:0] g,
                             input logic [2:0] c, input logic t);
      tests_run++;
      if ({bus.gnt, bus.gnt_code, bus.timeout} !== {g, c, t}) begin
         tests_failed++;
         $display("FAIL %s: gnt=%b code=%b timeout=%b, expected gnt=%b code=%b timeout=%b",
                  name, bus.gnt, bus.gnt_code, bus.timeout, g, c, t);
      end
   endtask

   // Reset overrides active requests.
   task automatic test_reset();
      rst = 1'b1; bus.req = 4'b1111; bus.done = 1'b0;
      tick();
      tick();
      expect_out("reset_state", 4'b0000, 3'b000, 1'b0);
   endtask

   // First grant comes from ptr=0. After done, ptr=2 is visible through the next winner.
   task automatic test_reset_then_grant();
      rst = 1'b0; bus.req = 4'b1010;
      tick();
      expect_out("first_grant", 4'b0010, 3'b101, 1'b0);
      bus.done = 1'b1;
      tick();
      expect_out("done_release", 4'b0000, 3'b000, 1'b0);
      bus.done = 1'b0;
      tick();
      expect_out("ptr_is_2", 4'b1000, 3'b111, 1'b0);
      bus.req = 4'b0000;                 // the owner drops its request, so ptr becomes 0
      tick();
      expect_out("drop_release", 4'b0000, 3'b000, 1'b0);
      tick();
      expect_out("idle_no_req", 4'b0000, 3'b000, 1'b0);
   endtask

   // All four requesters active. Each grant is ended by a done pulse.
   task automatic test_rotation();
      logic [3:0] rot_gnt [5];
      logic [2:0] rot_code [5];
      rot_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rot_code = '{3'b100,  3'b101,  3'b110,  3'b111,  3'b100};
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         expect_out($sformatf("rot_grant%0d", k), rot_gnt[k], rot_code[k], 1'b0);
         bus.done = 1'b1;
         tick();
         expect_out($sformatf("rot_gap%0d", k), 4'b0000, 3'b000, 1'b0);
         bus.done = 1'b0;
      end
      bus.req = 4'b0000;                 // ptr is now 1
   endtask

   // Hold limit: 8 grant cycles, then a timeout pulse, then a regrant.
   // A done pulse on the limit edge suppresses the timeout pulse.
   task automatic test_timeout();
      bus.req = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         tick();
         expect_out($sformatf("hold_cycle%0d", k), 4'b0100, 3'b110, 1'b0);
      end
      tick();
      expect_out("timeout_pulse", 4'b0000, 3'b000, 1'b1);
      tick();
      expect_out("regrant_after_timeout", 4'b0100, 3'b110, 1'b0);
      for (int k = 0; k < 7; k++) tick();
      expect_out("hold_last_cycle", 4'b0100, 3'b110, 1'b0);
      bus.done = 1'b1;                   // coincides with the hold-limit edge
      tick();
      expect_out("simultaneous_no_timeout", 4'b0000, 3'b000, 1'b0);
      bus.done = 1'b0;
      bus.req  = 4'b0000;
      tick();
      bus.done = 1'b1;                   // done while IDLE must be ignored
      tick();
      expect_out("done_in_idle", 4'b0000, 3'b000, 1'b0);
      bus.done = 1'b0;                   // ptr is now 3
   endtask

   // The owner drops its request while another requester is waiting.
   task automatic test_owner_drop();
      bus.req = 4'b1000;
      tick();
      expect_out("owner3_grant", 4'b1000, 3'b111, 1'b0);
      bus.req = 4'b0001;
      tick();
      expect_out("owner_drop_release", 4'b0000, 3'b000, 1'b0);
      tick();
      expect_out("grant_after_drop", 4'b0001, 3'b100, 1'b0);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;                   // ptr is now 1
      bus.req  = 4'b0000;
   endtask

   // Reset while a grant is held. ptr returns to 0, which selects requester 0
   // over requester 3.
   task automatic test_reset_mid_grant();
      bus.req = 4'b1000;
      tick();
      expect_out("pre_reset_grant", 4'b1000, 3'b111, 1'b0);
      rst = 1'b1;
      tick();
      expect_out("reset_mid_grant", 4'b0000, 3'b000, 1'b0);
      rst = 1'b0;
      bus.req = 4'b1001;
      tick();
      expect_out("grant_after_reset", 4'b0001, 3'b100, 1'b0);
   endtask

   initial begin
      test_reset();
      test_reset_then_grant();
      test_rotation();
      test_timeout();
      test_owner_drop();
      test_reset_mid_grant();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_rr_arbiter4
